// File: rtl/fft_pkg.sv
// Shared constants, bank state type and bit-reversal helper for the FFT output reorder buffer.
// Optional input-order bypass is enabled by defining FFT_REORDER_BYPASS_EN.
package fft_pkg;

  localparam int unsigned FFT_N_LOG2 = 8;
  localparam int unsigned FFT_W      = 16;

  // Widest index bitrev() supports; callers cast the result down to their own width.
  localparam int unsigned BITREV_W = 16;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Reverses the low n bits of v; the result occupies the low n bits.
  function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] v,
                                                 input int unsigned n);
    logic [BITREV_W-1:0] src;
    logic [BITREV_W-1:0] res;
    src = v;
    res = '0;
    for (int unsigned k = 0; k < BITREV_W; k++) begin
      if (k < n) begin
        res = {res[BITREV_W-2:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample-in / sample-out handshake bundle of the FFT reorder buffer.
// The bypass signal exists only when FFT_REORDER_BYPASS_EN is defined.
interface fft_bitrev_reorder_if
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = FFT_N_LOG2,
  parameter int unsigned W      = FFT_W
);

  logic [W-1:0]      din_r;
  logic [W-1:0]      din_i;
  logic              din_valid;
  logic              din_ready;
`ifdef FFT_REORDER_BYPASS_EN
  logic              bypass;
`endif
  logic [W-1:0]      dout_r;
  logic [W-1:0]      dout_i;
  logic [N_LOG2-1:0] dout_idx;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_sof;
  logic              dout_eof;

  // Upstream producer plus downstream consumer.
  modport master (
`ifdef FFT_REORDER_BYPASS_EN
    output bypass,
`endif
    output din_r,
    output din_i,
    output din_valid,
    input  din_ready,
    input  dout_r,
    input  dout_i,
    input  dout_idx,
    input  dout_valid,
    output dout_ready,
    input  dout_sof,
    input  dout_eof
  );

  // The reorder buffer itself.
  modport slave (
`ifdef FFT_REORDER_BYPASS_EN
    input  bypass,
`endif
    input  din_r,
    input  din_i,
    input  din_valid,
    output din_ready,
    output dout_r,
    output dout_i,
    output dout_idx,
    output dout_valid,
    input  dout_ready,
    output dout_sof,
    output dout_eof
  );

endinterface

// File: rtl/fft_reorder_bank.sv
// One ping-pong half: N x 2W storage, its fill/drain state machine and stored bypass flag.
// FFT_REORDER_BYPASS_EN adds the wr_bypass input sampled on the first write of a frame.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = FFT_N_LOG2,
  parameter int unsigned W      = FFT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [N_LOG2-1:0] wr_cnt,
  input  logic [2*W-1:0]    wr_data,
`ifdef FFT_REORDER_BYPASS_EN
  input  logic              wr_bypass,
`endif
  input  logic              rd_en,
  input  logic [N_LOG2-1:0] rd_addr,
  output logic [2*W-1:0]    rd_data,
  output bank_state_t       state
);

  localparam int unsigned N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = '1;

  logic [2*W-1:0]    mem [N];
  logic [N_LOG2-1:0] wr_addr;
  logic [N_LOG2-1:0] wr_addr_rev;
  bank_state_t       state_q;
  bank_state_t       state_d;
  logic              wr_last;
  logic              rd_last;

  assign wr_addr_rev = N_LOG2'(bitrev(BITREV_W'(wr_cnt), N_LOG2));
  assign wr_last     = (wr_cnt == LAST);
  assign rd_last     = (rd_addr == LAST);

`ifdef FFT_REORDER_BYPASS_EN
  logic bypass_q;
  logic bypass_cur;

  // The first write of a frame lands while the bank is EMPTY, so use the live flag then.
  assign bypass_cur = (state_q == EMPTY) ? wr_bypass : bypass_q;
  assign wr_addr    = bypass_cur ? wr_cnt : wr_addr_rev;

  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else if (wr_en && (state_q == EMPTY)) begin
      bypass_q <= wr_bypass;
    end
  end
`else
  assign wr_addr = wr_addr_rev;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:    if (wr_en) state_d = wr_last ? FULL : FILLING;
      FILLING:  if (wr_en && wr_last) state_d = FULL;
      FULL:     if (rd_en) state_d = rd_last ? EMPTY : DRAINING;
      DRAINING: if (rd_en && rd_last) state_d = EMPTY;
      default:  state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The top level guarantees exclusive access and writes only into a bank with room.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_en && rd_en));
      assert (!(wr_en && ((state_q == FULL) || (state_q == DRAINING))));
      assert (!(rd_en && ((state_q == EMPTY) || (state_q == FILLING))));
    end
  end

  assign rd_data = mem[rd_addr];
  assign state   = state_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer turning bit-reversed FFT frames into natural-order output frames.
// Defining FFT_REORDER_BYPASS_EN adds a per-frame bypass that keeps input order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = FFT_N_LOG2,
  parameter int unsigned W      = FFT_W
) (
  input logic                 CLK,
  input logic                 RST,
  fft_bitrev_reorder_if.slave bus
);

  localparam logic [N_LOG2-1:0] LAST = '1;

  logic              wb_q;
  logic              rb_q;
  logic [N_LOG2-1:0] wcnt_q;
  logic [N_LOG2-1:0] rcnt_q;

  bank_state_t       bank_state   [2];
  logic [2*W-1:0]    bank_rd_data [2];
  logic [1:0]        bank_wr_en;
  logic [1:0]        bank_rd_en;

  logic              in_ready;
  logic              wr_fire;
  logic              rd_avail;
  logic              rd_load;
  logic [2*W-1:0]    rd_word;

  logic [W-1:0]      dout_r_q;
  logic [W-1:0]      dout_i_q;
  logic [N_LOG2-1:0] dout_idx_q;
  logic              dout_valid_q;
  logic              dout_sof_q;
  logic              dout_eof_q;

  // Registered bank state only, so a bank freed by the reader opens up one cycle later.
  assign in_ready = (bank_state[wb_q] == EMPTY) || (bank_state[wb_q] == FILLING);
  assign wr_fire  = bus.din_valid && in_ready;
  assign rd_avail = (bank_state[rb_q] == FULL) || (bank_state[rb_q] == DRAINING);
  assign rd_load  = (!dout_valid_q || bus.dout_ready) && rd_avail;
  assign rd_word  = bank_rd_data[rb_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr_en[b] = wr_fire && (wb_q == 1'(b));
    assign bank_rd_en[b] = rd_load && (rb_q == 1'(b));

    fft_reorder_bank #(
      .N_LOG2(N_LOG2),
      .W     (W)
    ) u_bank (
      .clk      (CLK),
      .rst      (RST),
      .wr_en    (bank_wr_en[b]),
      .wr_cnt   (wcnt_q),
      .wr_data  ({bus.din_r, bus.din_i}),
`ifdef FFT_REORDER_BYPASS_EN
      .wr_bypass(bus.bypass),
`endif
      .rd_en    (bank_rd_en[b]),
      .rd_addr  (rcnt_q),
      .rd_data  (bank_rd_data[b]),
      .state    (bank_state[b])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_q   <= 1'b0;
      wcnt_q <= '0;
    end else if (wr_fire) begin
      wcnt_q <= wcnt_q + 1'b1;
      if (wcnt_q == LAST) begin
        wb_q <= ~wb_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rb_q         <= 1'b0;
      rcnt_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_r_q     <= '0;
      dout_i_q     <= '0;
      dout_idx_q   <= '0;
      dout_sof_q   <= 1'b0;
      dout_eof_q   <= 1'b0;
    end else if (rd_load) begin
      dout_valid_q <= 1'b1;
      dout_r_q     <= rd_word[2*W-1:W];
      dout_i_q     <= rd_word[W-1:0];
      dout_idx_q   <= rcnt_q;
      dout_sof_q   <= (rcnt_q == '0);
      dout_eof_q   <= (rcnt_q == LAST);
      rcnt_q       <= rcnt_q + 1'b1;
      if (rcnt_q == LAST) begin
        rb_q <= ~rb_q;
      end
    end else if (bus.dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign bus.din_ready  = in_ready;
  assign bus.dout_r     = dout_r_q;
  assign bus.dout_i     = dout_i_q;
  assign bus.dout_idx   = dout_idx_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_sof   = dout_sof_q;
  assign bus.dout_eof   = dout_eof_q;

endmodule
